// File: rtl/inject_packetizer.sv
// inject_packetizer: wraps a word stream into NoC packets (header flit, size
// flit, payload words) for a credit-based injection port. A small FIFO lets the
// loader run ahead of NoC backpressure, including prefetch while the header and
// size flits are still waiting for credit.
module inject_packetizer #(
  parameter int FLIT_SIZE   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [15:0]          target_i,
  input  logic [15:0]          size_i,
  output logic                 req_ack_o,
  output logic                 err_o,
  input  logic                 word_valid_i,
  input  logic [FLIT_SIZE-1:0] word_i,
  output logic                 word_ready_o,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 eop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [16:0] MAX_C   = 17'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t              state;
  logic [15:0]         target_q, size_q, rem_in, rem_out;
  logic [FLIT_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                fifo_full, fifo_empty, push, pop;

  assign fifo_full    = (count == DEPTH_C);
  assign fifo_empty   = (count == '0);
  assign word_ready_o = !fifo_full && (rem_in != 16'd0) && (state != IDLE);
  assign push         = word_valid_i && word_ready_o;
  // Only payload flits come out of the FIFO; header/size are built from the latched request.
  assign pop          = (state == PAYLOAD) && !fifo_empty && credit_i;
  assign busy_o       = (state != IDLE);

  // Flit presentation decoded from the registered state and FIFO head.
  always_comb begin
    tx_o   = 1'b0;
    data_o = '0;
    eop_o  = 1'b0;
    case (state)
      HEADER: begin
        tx_o   = 1'b1;
        data_o = {{(FLIT_SIZE-16){1'b0}}, target_q};
      end
      SIZE: begin
        tx_o   = 1'b1;
        data_o = {{(FLIT_SIZE-16){1'b0}}, size_q};
        eop_o  = (size_q == 16'd0);
      end
      PAYLOAD: begin
        tx_o   = !fifo_empty;
        data_o = fifo_empty ? '0 : mem[rd_ptr];
        eop_o  = !fifo_empty && (rem_out == 16'd1);
      end
      default: ;
    endcase
  end

  // Payload storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= word_i;
  end

  // FIFO pointers and occupancy; reset flushes any abandoned packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Packet FSM: request intake, flit sequencing and word/flit countdowns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      target_q  <= '0;
      size_q    <= '0;
      rem_in    <= '0;
      rem_out   <= '0;
      req_ack_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      req_ack_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            req_ack_o <= 1'b1;
            if ({1'b0, size_i} > MAX_C) begin
              err_o <= 1'b1;
            end else begin
              target_q <= target_i;
              size_q   <= size_i;
              rem_in   <= size_i;
              rem_out  <= size_i;
              state    <= HEADER;
            end
          end
        end
        HEADER: if (credit_i) state <= SIZE;
        SIZE:   if (credit_i) state <= (size_q == 16'd0) ? IDLE : PAYLOAD;
        PAYLOAD: begin
          if (pop) begin
            rem_out <= rem_out - 16'd1;
            if (rem_out == 16'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // word_ready_o is low in IDLE, so this never collides with the latch above
      if (push) rem_in <= rem_in - 16'd1;
    end
  end

endmodule

// File: tb/tb_inject_packetizer.sv
// Scoreboard bench for inject_packetizer: each request pushes its expected flit
// sequence and ack/err outcome; a negedge monitor pops and compares every flit
// transfer and ack, and checks hold-while-stalled and idle invariants.
module tb_inject_packetizer;
  localparam int FLIT_SIZE   = 32;
  localparam int FIFO_DEPTH  = 8;
  localparam int MAX_PAYLOAD = 1024;

  logic        clk_i = 0, rst_ni = 0, req_i = 0;
  logic [15:0] target_i = 0, size_i = 0;
  logic        req_ack_o, err_o, word_ready_o, tx_o, busy_o, eop_o;
  logic        word_valid_i = 0, credit_i = 0;
  logic [31:0] word_i = 0, data_o;

  inject_packetizer #(.FLIT_SIZE(FLIT_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PAYLOAD(MAX_PAYLOAD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .target_i(target_i), .size_i(size_i),
    .req_ack_o(req_ack_o), .err_o(err_o), .word_valid_i(word_valid_i), .word_i(word_i),
    .word_ready_o(word_ready_o), .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o),
    .busy_o(busy_o), .eop_o(eop_o));

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] data; logic eop; } flit_t;
  flit_t       exp_q[$];
  logic [31:0] word_q[$];
  logic        ack_q[$];
  int checks = 0, errors = 0, accepted = 0, credit_mode = 3;
  bit always_valid = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Credit pattern: 0 random, 1 toggle, 2 withheld, 3 always granted.
  initial forever begin
    @(posedge clk_i); #1;
    case (credit_mode)
      0: credit_i = ($urandom % 3) != 0;
      1: credit_i = ~credit_i;
      2: credit_i = 1'b0;
      default: credit_i = 1'b1;
    endcase
  end

  // Loader model: offers queued words in order, gaps when not always_valid.
  initial forever begin
    @(posedge clk_i); #1;
    if (rst_ni && word_q.size() > 0 && (always_valid || ($urandom % 4) != 0)) begin
      word_valid_i = 1'b1;
      word_i       = word_q[0];
    end else begin
      word_valid_i = 1'b0;
    end
    @(negedge clk_i);
    if (rst_ni && word_valid_i && word_ready_o) begin
      void'(word_q.pop_front());
      accepted++;
    end
  end

  // Monitor: compares every transfer and ack against the scoreboard.
  initial begin
    logic        prev_stall = 0, prev_eop_xfer = 0, prev_eop = 0;
    logic [31:0] prev_data = 0;
    flit_t       f;
    logic        e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 0;
        prev_eop_xfer = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_tx", 32'(tx_o), 32'd1);
          chk("hold_data", data_o, prev_data);
          chk("hold_eop", 32'(eop_o), 32'(prev_eop));
        end
        if (prev_eop_xfer) chk("busy_after_eop", 32'(busy_o), 32'd0);
        if (!busy_o) chk("ready_while_idle", 32'(word_ready_o), 32'd0);
        if (req_ack_o) begin
          if (ack_q.size() == 0) fail_now("unexpected_ack");
          else begin
            e = ack_q.pop_front();
            chk("err_with_ack", 32'(err_o), 32'(e));
          end
        end else if (err_o) fail_now("err_without_ack");
        prev_eop_xfer = 0;
        if (tx_o && credit_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_flit");
          else begin
            f = exp_q.pop_front();
            chk("flit_data", data_o, f.data);
            chk("flit_eop", 32'(eop_o), 32'(f.eop));
          end
          prev_eop_xfer = eop_o;
        end
        prev_stall = tx_o && !credit_i;
        prev_data  = data_o;
        prev_eop   = eop_o;
      end
    end
  end

  // Reference: a packet is its header, its size, then its words; oversize is only an error ack.
  task automatic issue(input logic [15:0] t, input logic [15:0] s);
    logic [31:0] w;
    bit got;
    if (int'(s) > MAX_PAYLOAD) ack_q.push_back(1'b1);
    else begin
      ack_q.push_back(1'b0);
      exp_q.push_back('{{16'h0, t}, 1'b0});
      exp_q.push_back('{{16'h0, s}, (s == 16'd0)});
      for (int i = 0; i < int'(s); i++) begin
        w = $urandom;
        word_q.push_back(w);
        exp_q.push_back('{w, (i == int'(s) - 1)});
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b1; target_i = t; size_i = s;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk_i); #1;
      got = req_ack_o;
    end
    req_i = 1'b0;
    if (!got) fail_now("ack_timeout");
  endtask

  task automatic wait_idle(output int busy_cycles);
    bit done = 0;
    busy_cycles = 0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk_i);
      if (busy_o) busy_cycles++;
      done = !busy_o && exp_q.size() == 0;
    end
    if (!done) fail_now("packet_timeout");
  endtask

  initial begin
    int bc, a0;
    logic [15:0] s;
    #2;
    chk("reset_tx", 32'(tx_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_ack", 32'(req_ack_o), 32'd0);
    chk("reset_ready", 32'(word_ready_o), 32'd0);
    chk("reset_data", data_o, 32'd0);
    chk("reset_eop", 32'(eop_o), 32'd0);
    #20;
    @(negedge clk_i) rst_ni = 1'b1;

    // basic packet, full credit: header, size, 3 words back to back
    credit_mode = 3; always_valid = 1;
    issue(16'h0102, 16'd3);
    wait_idle(bc);
    chk("t1_busy_cycles", 32'(bc), 32'd5);

    // empty packet: only header and size flits
    issue(16'h0102, 16'd0);
    wait_idle(bc);
    chk("t2_busy_cycles", 32'(bc), 32'd2);

    // toggling credit with a longer packet
    credit_mode = 1;
    issue(16'h0a0b, 16'd20);
    wait_idle(bc);

    // oversize request: error ack only, nothing transmitted
    credit_mode = 3;
    issue(16'h0102, 16'd1025);
    chk("t4_tx", 32'(tx_o), 32'd0);
    chk("t4_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("t4_tx_later", 32'(tx_o), 32'd0);

    // credit withheld: the FIFO fills to depth and the loader is held off
    credit_mode = 2;
    a0 = accepted;
    issue(16'h0203, 16'd16);
    repeat (50) @(negedge clk_i);
    chk("t5_words_buffered", 32'(accepted - a0), 32'(FIFO_DEPTH));
    chk("t5_ready_low", 32'(word_ready_o), 32'd0);
    credit_mode = 3;
    wait_idle(bc);

    // largest legal size
    credit_mode = 0; always_valid = 0;
    issue(16'hff00, 16'(MAX_PAYLOAD));
    wait_idle(bc);

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      s = (($urandom % 8) == 0) ? 16'(1025 + $urandom % 100) : 16'($urandom % 41);
      issue(16'($urandom), s);
      wait_idle(bc);
      if (($urandom % 2) == 0) repeat ($urandom % 4) @(posedge clk_i);
    end

    // reset in the middle of a payload, then a clean packet
    credit_mode = 3; always_valid = 1;
    issue(16'h0304, 16'd10);
    for (int n = 0; n < 200 && exp_q.size() > 8; n++) @(negedge clk_i);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    exp_q.delete(); word_q.delete(); ack_q.delete();
    #1;
    chk("t6_tx_at_reset", 32'(tx_o), 32'd0);
    chk("t6_busy_at_reset", 32'(busy_o), 32'd0);
    chk("t6_data_at_reset", data_o, 32'd0);
    chk("t6_ready_at_reset", 32'(word_ready_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    issue(16'h0102, 16'd2);
    wait_idle(bc);
    chk("t6_busy_cycles", 32'(bc), 32'd4);

    repeat (5) @(negedge clk_i);
    chk("end_flits_left", 32'(exp_q.size()), 32'd0);
    chk("end_words_left", 32'(word_q.size()), 32'd0);
    chk("end_acks_left", 32'(ack_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
